// File: rtl/md_pkg.sv
// Shared definitions for the pair sweep scheduler and its output queue.
//   PARTICLE_W : one particle slot, {null flag, x, y, z} with fp32 coordinates
//   PAIR_W     : one accepted pair, {ref position, nbr position}
//   FILT_O_W   : filter result, {reject, ref position, nbr position}
//   state_t    : sweep sequencer states
package md_pkg;

    localparam int PARTICLE_W = 97;
    localparam int NULL_BIT   = 96;
    localparam int POS_W      = 96;
    localparam int PAIR_W     = 192;
    localparam int CELL_ID_W  = 8;
    localparam int FILT_O_W   = 193;

    typedef enum logic [1:0] {
        IDLE,
        REF_WAIT,
        SWEEP,
        DRAIN
    } state_t;

endpackage

// File: rtl/pair_fifo2.sv
// Two-entry first-word-fall-through queue for accepted particle pairs.
//   clk, rst   : clock, synchronous active-high reset (empties the queue)
//   push       : write push_data (dropped only if full and not popping)
//   push_data  : pair to enqueue
//   pop        : consume head entry (ignored while empty)
//   pop_data   : head entry, valid whenever empty is low
//   full/empty : occupancy flags
module pair_fifo2
    import md_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [PAIR_W-1:0] push_data,
    input  logic              pop,
    output logic [PAIR_W-1:0] pop_data,
    output logic              full,
    output logic              empty
);

    logic [PAIR_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot the push needs.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/pair_sweep_scheduler.sv
// Walks every particle of a reference cell against every particle of a
// neighbour cell through an external combinational filter, and queues the
// accepted pairs for the force pipeline on a valid/ready stream.
//   clk, rst                   : clock, synchronous active-high reset
//   start, ref_cell, nbr_cell  : begin a sweep (sampled in IDLE only)
//   busy, done                 : sweep in progress / one-cycle completion pulse
//   ref_rd_*, nbr_rd_*         : 1-cycle-latency cell memory read ports
//   filt_*                     : operands to / result from the shared filter
//   pair_valid/ready/data      : accepted-pair output stream
//   pairs_checked/passed       : saturating per-sweep statistics
module pair_sweep_scheduler
    import md_pkg::*;
#(
    parameter int CELL_DEPTH = 32,
    parameter int ADDR_W     = 5,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CELL_ID_W-1:0]  ref_cell,
    input  logic [CELL_ID_W-1:0]  nbr_cell,
    output logic                  busy,
    output logic                  done,
    output logic                  ref_rd_en,
    output logic [ADDR_W-1:0]     ref_rd_addr,
    input  logic [PARTICLE_W-1:0] ref_rd_data,
    output logic                  nbr_rd_en,
    output logic [ADDR_W-1:0]     nbr_rd_addr,
    input  logic [PARTICLE_W-1:0] nbr_rd_data,
    output logic [PARTICLE_W-1:0] filt_reference,
    output logic [PARTICLE_W-1:0] filt_neighbor,
    output logic [CELL_ID_W-1:0]  filt_ref_cell,
    output logic [CELL_ID_W-1:0]  filt_nbr_cell,
    input  logic [FILT_O_W-1:0]   filt_o,
    output logic                  pair_valid,
    input  logic                  pair_ready,
    output logic [PAIR_W-1:0]     pair_data,
    output logic [CNT_W-1:0]      pairs_checked,
    output logic [CNT_W-1:0]      pairs_passed
);

    localparam logic [ADDR_W-1:0] LAST_SLOT = ADDR_W'(CELL_DEPTH - 1);

    state_t                state;
    state_t                state_next;
    logic [ADDR_W-1:0]     ref_addr;     // next reference slot to fetch
    logic [ADDR_W-1:0]     nbr_addr;     // slot currently on nbr_rd_data
    logic [PARTICLE_W-1:0] ref_reg;
    logic [CELL_ID_W-1:0]  ref_cell_q;
    logic [CELL_ID_W-1:0]  nbr_cell_q;
    logic [CNT_W-1:0]      checked_q;
    logic [CNT_W-1:0]      passed_q;
    logic                  busy_q;
    logic                  done_q;

    logic start_sweep;
    logic latch_ref;
    logic eval;
    logic push;
    logic row_end;
    logic fifo_full;
    logic fifo_empty;

    assign filt_reference = ref_reg;
    assign filt_neighbor  = nbr_rd_data;
    assign filt_ref_cell  = ref_cell_q;
    assign filt_nbr_cell  = nbr_cell_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign pairs_checked  = checked_q;
    assign pairs_passed   = passed_q;
    assign pair_valid     = !fifo_empty;

    always_comb begin
        state_next  = state;
        ref_rd_en   = 1'b0;
        ref_rd_addr = ref_addr;
        nbr_rd_en   = 1'b0;
        nbr_rd_addr = nbr_addr;
        start_sweep = 1'b0;
        latch_ref   = 1'b0;
        eval        = 1'b0;
        push        = 1'b0;
        row_end     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    start_sweep = 1'b1;
                    ref_rd_en   = 1'b1;
                    ref_rd_addr = '0;
                    state_next  = REF_WAIT;
                end
            end
            REF_WAIT: begin
                if (ref_rd_data[NULL_BIT]) begin
                    state_next = DRAIN;
                end else begin
                    latch_ref   = 1'b1;
                    nbr_rd_en   = 1'b1;
                    nbr_rd_addr = '0;
                    state_next  = SWEEP;
                end
            end
            SWEEP: begin
                // While the queue is full the neighbour memory holds its
                // output, so the same operand is re-evaluated once space frees.
                if (!fifo_full) begin
                    eval    = 1'b1;
                    push    = !filt_o[FILT_O_W-1] && !nbr_rd_data[NULL_BIT];
                    row_end = nbr_rd_data[NULL_BIT] || (nbr_addr == LAST_SLOT);
                    if (row_end) begin
                        // ref_addr wrapping to 0 means the last slot was used.
                        if (ref_addr == '0) begin
                            state_next = DRAIN;
                        end else begin
                            ref_rd_en  = 1'b1;
                            state_next = REF_WAIT;
                        end
                    end else begin
                        nbr_rd_en   = 1'b1;
                        nbr_rd_addr = nbr_addr + 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ref_addr   <= '0;
            nbr_addr   <= '0;
            ref_reg    <= {1'b1, {POS_W{1'b0}}};
            ref_cell_q <= '0;
            nbr_cell_q <= '0;
            checked_q  <= '0;
            passed_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state  <= state_next;
            busy_q <= (state_next != IDLE);
            done_q <= (state == DRAIN) && fifo_empty;
            if (start_sweep) begin
                ref_cell_q <= ref_cell;
                nbr_cell_q <= nbr_cell;
                checked_q  <= '0;
                passed_q   <= '0;
                ref_addr   <= '0;
            end
            if (latch_ref) begin
                ref_reg  <= ref_rd_data;
                ref_addr <= ref_addr + 1'b1;
                nbr_addr <= '0;
            end
            if (eval) begin
                if (checked_q != '1) begin
                    checked_q <= checked_q + 1'b1;
                end
                if (!row_end) begin
                    nbr_addr <= nbr_addr + 1'b1;
                end
            end
            if (push && (passed_q != '1)) begin
                passed_q <= passed_q + 1'b1;
            end
        end
    end

    pair_fifo2 u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (filt_o[PAIR_W-1:0]),
        .pop       (pair_ready),
        .pop_data  (pair_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_pair_sweep_scheduler.sv
module tb_pair_sweep_scheduler;
    import md_pkg::*;

    localparam int CELL_DEPTH = 32;
    localparam int ADDR_W     = 5;
    localparam int CNT_W      = 16;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [CELL_ID_W-1:0]  ref_cell;
    logic [CELL_ID_W-1:0]  nbr_cell;
    logic                  busy;
    logic                  done;
    logic                  ref_rd_en;
    logic [ADDR_W-1:0]     ref_rd_addr;
    logic [PARTICLE_W-1:0] ref_rd_data;
    logic                  nbr_rd_en;
    logic [ADDR_W-1:0]     nbr_rd_addr;
    logic [PARTICLE_W-1:0] nbr_rd_data;
    logic [PARTICLE_W-1:0] filt_reference;
    logic [PARTICLE_W-1:0] filt_neighbor;
    logic [CELL_ID_W-1:0]  filt_ref_cell;
    logic [CELL_ID_W-1:0]  filt_nbr_cell;
    logic [FILT_O_W-1:0]   filt_o;
    logic                  pair_valid;
    logic                  pair_ready;
    logic [PAIR_W-1:0]     pair_data;
    logic [CNT_W-1:0]      pairs_checked;
    logic [CNT_W-1:0]      pairs_passed;

    logic [PARTICLE_W-1:0] ref_mem [CELL_DEPTH];
    logic [PARTICLE_W-1:0] nbr_mem [CELL_DEPTH];
    logic                  reject_same;

    logic [PAIR_W-1:0] exp_q [$];
    int exp_checked;
    int exp_passed;
    int n_vec;
    int n_err;
    int n_done;
    int ref_reads;
    int nbr_reads;

    localparam logic [PARTICLE_W-1:0] NULL_P = {1'b1, 96'b0};

    pair_sweep_scheduler #(
        .CELL_DEPTH (CELL_DEPTH),
        .ADDR_W     (ADDR_W),
        .CNT_W      (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .ref_cell       (ref_cell),
        .nbr_cell       (nbr_cell),
        .busy           (busy),
        .done           (done),
        .ref_rd_en      (ref_rd_en),
        .ref_rd_addr    (ref_rd_addr),
        .ref_rd_data    (ref_rd_data),
        .nbr_rd_en      (nbr_rd_en),
        .nbr_rd_addr    (nbr_rd_addr),
        .nbr_rd_data    (nbr_rd_data),
        .filt_reference (filt_reference),
        .filt_neighbor  (filt_neighbor),
        .filt_ref_cell  (filt_ref_cell),
        .filt_nbr_cell  (filt_nbr_cell),
        .filt_o         (filt_o),
        .pair_valid     (pair_valid),
        .pair_ready     (pair_ready),
        .pair_data      (pair_data),
        .pairs_checked  (pairs_checked),
        .pairs_passed   (pairs_passed)
    );

    always #5 clk = ~clk;

    // Cell memories: 1-cycle read latency, output held while not enabled.
    always @(posedge clk) begin
        if (ref_rd_en) ref_rd_data <= ref_mem[ref_rd_addr];
        if (nbr_rd_en) nbr_rd_data <= nbr_mem[nbr_rd_addr];
    end

    // Filter model: optionally rejects a neighbour identical to the reference.
    assign filt_o = {reject_same && (filt_reference[95:0] == filt_neighbor[95:0]),
                     filt_reference[95:0], filt_neighbor[95:0]};

    task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares every transfer against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (ref_rd_en) ref_reads++;
            if (nbr_rd_en) nbr_reads++;
            if (done) n_done++;
            if (pair_valid && pair_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $error("FAIL extra_pair: observed %0h expected none", pair_data);
                end else begin
                    check("pair", pair_data, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PARTICLE_W-1:0] mk(input logic [3:0] base, input int i);
        logic [31:0] w;
        w = {base, 28'(i)};
        return {1'b0, w, w ^ 32'h5555_0000, w ^ 32'h0000_AAAA};
    endfunction

    task automatic fill_null();
        for (int i = 0; i < CELL_DEPTH; i++) begin
            ref_mem[i] = NULL_P;
            nbr_mem[i] = NULL_P;
        end
    endtask

    task automatic set_test2();
        fill_null();
        for (int i = 0; i < 2; i++) ref_mem[i] = mk(4'hA, i);
        for (int i = 0; i < 3; i++) nbr_mem[i] = mk(4'hD, i);
    endtask

    // Reference model of a sweep: row-major order, null ends a row/cell.
    task automatic build_expected();
        exp_q.delete();
        exp_checked = 0;
        exp_passed  = 0;
        for (int r = 0; r < CELL_DEPTH; r++) begin
            if (ref_mem[r][96]) break;
            for (int n = 0; n < CELL_DEPTH; n++) begin
                exp_checked++;
                if (nbr_mem[n][96]) break;
                if (!(reject_same && ref_mem[r][95:0] == nbr_mem[n][95:0])) begin
                    exp_q.push_back({ref_mem[r][95:0], nbr_mem[n][95:0]});
                    exp_passed++;
                end
            end
        end
    endtask

    task automatic start_sweep(input logic [7:0] rc, input logic [7:0] nc);
        n_done    = 0;
        ref_reads = 0;
        nbr_reads = 0;
        ref_cell  = rc;
        nbr_cell  = nc;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int found;
        found = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                break;
            end
        end
        check("done_seen", 192'(found), 192'd1);
        tick();
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_checked"}, 192'(pairs_checked), 192'(exp_checked));
        check({tag, "_passed"}, 192'(pairs_passed), 192'(exp_passed));
        check({tag, "_left"}, 192'(exp_q.size()), 192'd0);
        check({tag, "_ndone"}, 192'(n_done), 192'd1);
        check({tag, "_busy"}, 192'(busy), 192'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0; n_err = 0; n_done = 0; ref_reads = 0; nbr_reads = 0;
        rst = 1'b1; start = 1'b0; pair_ready = 1'b1; reject_same = 1'b0;
        ref_cell = '0; nbr_cell = '0;
        fill_null();
        repeat (3) tick();
        check("rst_busy", 192'(busy), 192'd0);
        check("rst_done", 192'(done), 192'd0);
        check("rst_valid", 192'(pair_valid), 192'd0);
        check("rst_ref_en", 192'(ref_rd_en), 192'd0);
        check("rst_nbr_en", 192'(nbr_rd_en), 192'd0);
        check("rst_checked", 192'(pairs_checked), 192'd0);
        check("rst_passed", 192'(pairs_passed), 192'd0);
        check("rst_ref_reg", 192'(filt_reference), 192'(NULL_P));
        rst = 1'b0;
        tick();

        // 1: null reference in slot 0
        fill_null();
        start_sweep(8'h11, 8'h22);
        check("t1_busy", 192'(busy), 192'd1);
        tick();
        check("t1_done_early", 192'(done), 192'd0);
        tick();
        check("t1_done", 192'(done), 192'd1);
        check("t1_busy_end", 192'(busy), 192'd0);
        tick();
        check("t1_done_pulse", 192'(done), 192'd0);
        check("t1_checked", 192'(pairs_checked), 192'd0);
        check("t1_nbr_reads", 192'(nbr_reads), 192'd0);
        check("t1_ref_reads", 192'(ref_reads), 192'd1);
        check("t1_ref_cell", 192'(filt_ref_cell), 192'h11);
        check("t1_nbr_cell", 192'(filt_nbr_cell), 192'h22);

        // 2: 2 references x (3 neighbours + null)
        set_test2();
        build_expected();
        check("t2_model", 192'(exp_passed), 192'd6);
        start_sweep(8'h01, 8'h02);
        wait_done(100);
        end_checks("t2");
        check("t2_checked_abs", 192'(pairs_checked), 192'd8);

        // 3: downstream stalls with the queue full
        build_expected();
        pair_ready = 1'b0;
        start_sweep(8'h01, 8'h02);
        repeat (3) tick();
        for (int i = 0; i < 7; i++) begin
            check("t3_addr_frozen", 192'(nbr_rd_addr), 192'd2);
            check("t3_nbr_en_off", 192'(nbr_rd_en), 192'd0);
            check("t3_valid", 192'(pair_valid), 192'd1);
            tick();
        end
        pair_ready = 1'b1;
        wait_done(100);
        end_checks("t3");

        // 4: both cells full
        for (int i = 0; i < CELL_DEPTH; i++) begin
            ref_mem[i] = {1'b0, $urandom(), $urandom(), $urandom()};
            nbr_mem[i] = {1'b0, $urandom(), $urandom(), $urandom()};
        end
        build_expected();
        start_sweep(8'h03, 8'h04);
        wait_done(2000);
        end_checks("t4");
        check("t4_passed_abs", 192'(pairs_passed), 192'd1024);
        check("t4_ref_reads", 192'(ref_reads), 192'd32);
        check("t4_nbr_reads", 192'(nbr_reads), 192'd1024);
        repeat (3) tick();
        check("t4_held", 192'(pairs_passed), 192'd1024);

        // 5: self-cell sweep, filter rejects identical particles
        fill_null();
        for (int i = 0; i < 4; i++) begin
            ref_mem[i] = mk(4'h7, i);
            nbr_mem[i] = mk(4'h7, i);
        end
        reject_same = 1'b1;
        build_expected();
        start_sweep(8'h5A, 8'h5A);
        wait_done(200);
        end_checks("t5");
        check("t5_passed_abs", 192'(pairs_passed), 192'd12);
        check("t5_checked_abs", 192'(pairs_checked), 192'd20);
        check("t5_cells", 192'({filt_ref_cell, filt_nbr_cell}), 192'h5A5A);
        reject_same = 1'b0;

        // 6: reset mid-sweep with the queue full, then a clean rerun of test 2
        set_test2();
        exp_q.delete();
        pair_ready = 1'b0;
        start_sweep(8'h01, 8'h02);
        repeat (3) tick();
        check("t6_full_valid", 192'(pair_valid), 192'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_busy", 192'(busy), 192'd0);
        check("t6_valid", 192'(pair_valid), 192'd0);
        check("t6_done", 192'(done), 192'd0);
        pair_ready = 1'b1;
        repeat (4) tick();
        check("t6_no_done", 192'(n_done), 192'd0);
        check("t6_idle", 192'(busy), 192'd0);
        build_expected();
        start_sweep(8'h01, 8'h02);
        wait_done(100);
        end_checks("t6");
        check("t6_checked_abs", 192'(pairs_checked), 192'd8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
